mips_cpu_reg_writeback: RTL and testbench



---
 rtl/mips_cpu_reg_writeback.sv | 105 ++++++++++
 tb/tb_mips_cpu_reg_writeback.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_reg_writeback.sv
// Register-file write-port driver: merges ALU results with FIFO-buffered memory/mult-div
// results, issues one registered write per cycle and tracks pending writes in a busy bitmap.
module mips_cpu_reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_reg,
  input  logic [31:0]              alu_data,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_reg,
  input  logic [31:0]              mem_data,
  output logic                     mem_ready,
  input  logic                     reserve_en,
  input  logic [4:0]               reserve_reg,
  output logic [4:0]               write_reg,
  output logic [31:0]              write_data,
  output logic                     write_en,
  output logic [31:0]              busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  logic [4:0]    fifo_reg  [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        push;
  logic        pop;
  logic [4:0]  head_reg;
  logic [31:0] head_data;
  logic [31:0] busy_next;

  assign mem_ready  = !reset && (count < FULL_LEVEL);
  assign fifo_level = count;
  assign push       = mem_valid && mem_ready;
  // ALU has fixed priority; the FIFO only drains in cycles without an ALU result.
  assign pop        = !alu_valid && (count != '0);
  assign head_reg   = fifo_reg[rd_ptr];
  assign head_data  = fifo_data[rd_ptr];

  // NOTE: the storage array is deliberately not reset; the pointers and count define which
  // slots are valid, so stale contents can never be observed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[wr_ptr]  <= mem_reg;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Writes to register 0 consume their slot but never raise the write enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_en   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else if (alu_valid) begin
      write_en   <= (alu_reg != 5'd0);
      write_reg  <= alu_reg;
      write_data <= alu_data;
    end else if (pop) begin
      write_en   <= (head_reg != 5'd0);
      write_reg  <= head_reg;
      write_data <= head_data;
    end else begin
      write_en   <= 1'b0;
    end
  end

  // NOTE: defaulting busy_next first keeps this block latch-free; the set is applied after
  // the clear so a same-register reserve wins over the retiring write.
  always_comb begin
    busy_next = busy;
    if (write_en)
      busy_next[write_reg] = 1'b0;
    if (reserve_en)
      busy_next[reserve_reg] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

endmodule

// File: tb/tb_mips_cpu_reg_writeback.sv
// Directed bench for mips_cpu_reg_writeback: ALU path, FIFO latency, backpressure,
// scoreboard set/clear priority, register-0 handling and mid-operation reset.
module tb_mips_cpu_reg_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        reserve_en;
  logic [4:0]  reserve_reg;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        write_en;
  logic [31:0] busy;
  logic [2:0]  fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  mips_cpu_reg_writeback #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .reserve_en(reserve_en), .reserve_reg(reserve_reg),
    .write_reg(write_reg), .write_data(write_data), .write_en(write_en),
    .busy(busy), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    mem_valid = 0; mem_reg = 0; mem_data = 0;
    reserve_en = 0; reserve_reg = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    n_cmp++;
    if ({write_en, write_reg, write_data} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_write: got en=%0b reg=%0d data=%h want 0/0/0", write_en, write_reg, write_data);
    end
    n_cmp++;
    if ({busy, fifo_level, mem_ready} !== 36'd0) begin
      n_err++;
      $display("FAIL reset_state: got busy=%h level=%0d ready=%0b want 0/0/0", busy, fifo_level, mem_ready);
    end
    reset = 0;
    #1;
    n_cmp++;
    if (mem_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready_after: got %0b want 1", mem_ready);
    end
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_reg = 5; alu_data = 32'hDEADBEEF;
    step();
    alu_valid = 0;
    n_cmp++;
    if ({write_en, write_reg, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL alu_write: got en=%0b reg=%0d data=%h want 1/5/deadbeef", write_en, write_reg, write_data);
    end
    step();
    n_cmp++;
    if ({write_en, write_reg, write_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL alu_hold: got en=%0b reg=%0d data=%h want 0/5/deadbeef", write_en, write_reg, write_data);
    end
  endtask

  task automatic test_mem_latency();
    reserve_en = 1; reserve_reg = 7;
    step();
    reserve_en = 0;
    n_cmp++;
    if (busy !== 32'h0000_0080) begin
      n_err++;
      $display("FAIL reserve_busy: got %h want 00000080", busy);
    end
    mem_valid = 1; mem_reg = 7; mem_data = 32'h12345678;
    step();  // accepted at this edge
    mem_valid = 0;
    n_cmp++;
    if ({write_en, fifo_level} !== {1'b0, 3'd1}) begin
      n_err++;
      $display("FAIL mem_queued: got en=%0b level=%0d want 0/1", write_en, fifo_level);
    end
    step();
    n_cmp++;
    if ({write_en, write_reg, write_data, busy} !== {1'b1, 5'd7, 32'h12345678, 32'h0000_0080}) begin
      n_err++;
      $display("FAIL mem_write: got en=%0b reg=%0d data=%h busy=%h want 1/7/12345678/00000080",
               write_en, write_reg, write_data, busy);
    end
    step();
    n_cmp++;
    if ({write_en, busy, fifo_level} !== {1'b0, 32'd0, 3'd0}) begin
      n_err++;
      $display("FAIL mem_retired: got en=%0b busy=%h level=%0d want 0/0/0", write_en, busy, fifo_level);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_reg = 5'(1 + c); alu_data = 32'hA000_0000 + 32'(c);
      mem_valid = 1; mem_reg = 5'(10 + c); mem_data = 32'h0000_0100 + 32'(c);
      step();
    end
    idle_inputs();
    n_cmp++;
    if ({fifo_level, mem_ready} !== {3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL fill_full: got level=%0d ready=%0b want 4/0", fifo_level, mem_ready);
    end
    n_cmp++;
    if ({write_en, write_reg, write_data} !== {1'b1, 5'd6, 32'hA000_0005}) begin
      n_err++;
      $display("FAIL fill_last_alu: got en=%0b reg=%0d data=%h want 1/6/a0000005", write_en, write_reg, write_data);
    end
    // Only the first four offers (regs 10..13) fit; they drain in order.
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({write_en, write_reg, write_data} !== {1'b1, 5'(10 + i), 32'h0000_0100 + 32'(i)}) begin
        n_err++;
        $display("FAIL drain_%0d: got en=%0b reg=%0d data=%h want 1/%0d/%h",
                 i, write_en, write_reg, write_data, 10 + i, 32'h0000_0100 + 32'(i));
      end
    end
    step();
    n_cmp++;
    if ({write_en, fifo_level, mem_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL drain_done: got en=%0b level=%0d ready=%0b want 0/0/1", write_en, fifo_level, mem_ready);
    end
  endtask

  task automatic test_scoreboard();
    reserve_en = 1; reserve_reg = 9;
    alu_valid = 1; alu_reg = 9; alu_data = 32'h9;
    step();
    alu_valid = 0;  // write_en for reg 9 is live now; reserve it again this cycle
    step();
    reserve_en = 0;
    n_cmp++;
    if (busy !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL set_wins: got busy=%h want 00000200", busy);
    end
    step();
    n_cmp++;
    if (busy !== 32'h0000_0200) begin
      n_err++;
      $display("FAIL busy_hold: got busy=%h want 00000200", busy);
    end
    alu_valid = 1; alu_reg = 9; alu_data = 32'h99;
    step();
    alu_valid = 0;
    step();
    n_cmp++;
    if (busy !== 32'd0) begin
      n_err++;
      $display("FAIL busy_clear: got busy=%h want 00000000", busy);
    end
    reserve_en = 1; reserve_reg = 0;
    step();
    reserve_en = 0;
    n_cmp++;
    if (busy !== 32'd0) begin
      n_err++;
      $display("FAIL reserve_r0: got busy=%h want 00000000", busy);
    end
  endtask

  task automatic test_reg0();
    alu_valid = 1; alu_reg = 0; alu_data = 32'hFFFFFFFF;
    step();
    alu_valid = 0;
    n_cmp++;
    if ({write_en, write_reg, write_data, busy} !== {1'b0, 5'd0, 32'hFFFFFFFF, 32'd0}) begin
      n_err++;
      $display("FAIL alu_r0: got en=%0b reg=%0d data=%h busy=%h want 0/0/ffffffff/0",
               write_en, write_reg, write_data, busy);
    end
    mem_valid = 1; mem_reg = 0; mem_data = 32'hAAAA5555;
    step();
    mem_valid = 0;
    step();
    n_cmp++;
    if ({write_en, write_reg, write_data, fifo_level} !== {1'b0, 5'd0, 32'hAAAA5555, 3'd0}) begin
      n_err++;
      $display("FAIL mem_r0: got en=%0b reg=%0d data=%h level=%0d want 0/0/aaaa5555/0",
               write_en, write_reg, write_data, fifo_level);
    end
  endtask

  task automatic test_reset_mid();
    reserve_en = 1; reserve_reg = 3;
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1; alu_reg = 5'(20 + c); alu_data = 32'hB0 + 32'(c);
      mem_valid = 1; mem_reg = 5'(25 + c); mem_data = 32'hC0 + 32'(c);
      step();
      reserve_en = 0;
    end
    idle_inputs();
    n_cmp++;
    if ({fifo_level, write_en, busy[3]} !== {3'd3, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset: got level=%0d en=%0b busy3=%0b want 3/1/1", fifo_level, write_en, busy[3]);
    end
    reset = 1;
    #1;
    n_cmp++;
    if (mem_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_in_reset: got %0b want 0", mem_ready);
    end
    step();
    n_cmp++;
    if ({fifo_level, busy, write_en, mem_ready} !== {3'd0, 32'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL mid_reset: got level=%0d busy=%h en=%0b ready=%0b want 0/0/0/0",
               fifo_level, busy, write_en, mem_ready);
    end
    reset = 0;
    #1;
    n_cmp++;
    if (mem_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_mid: got %0b want 1", mem_ready);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({write_en, fifo_level} !== {1'b0, 3'd0}) begin
        n_err++;
        $display("FAIL no_stale_%0d: got en=%0b level=%0d want 0/0", i, write_en, fifo_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_latency();
    test_back_to_back();
    test_scoreboard();
    test_reg0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
